fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch queue between the IF stage and the ID stage.
- Buffers fetched {pc, instruction, pc_plus4} triples in a small circular FIFO, so that ID stalls do not immediately freeze the program counter.
- Upstream sees backpressure through enq_ready_o, which drives pc_we.
- Downstream ID pops entries through a valid/ready handshake.
- A taken branch/jump (PCSrc) flushes every buffered wrong-path entry.

Parameters:
- DATA_WIDTH, 32: width of each of pc, instruction and pc_plus4.
- DEPTH, 4: number of entries. Power of two, >= 2.
- PTR_W, $clog2(DEPTH): read/write pointer width (derived).
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived).

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush_i  input  1  taken-branch/jump redirect (PCSrc), discards all entries
- enq_valid_i  input  1  IF presents a fetched instruction
- enq_pc_i  input  DATA_WIDTH  PC of fetched instruction
- enq_instr_i  input  DATA_WIDTH  fetched instruction word
- enq_pc_plus4_i  input  DATA_WIDTH  PC+4 of fetched instruction
- enq_ready_o  output  1  queue can accept an entry this cycle (to pc_we)
- deq_valid_o  output  1  head entry valid for ID
- deq_pc_o  output  DATA_WIDTH  head PC
- deq_instr_o  output  DATA_WIDTH  head instruction
- deq_pc_plus4_o  output  DATA_WIDTH  head PC+4
- deq_ready_i  input  1  ID accepts the head entry (ID not stalled)
- count_o  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, rst_n low): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs under reset: deq_valid_o=0, enq_ready_o=1, count_o=0, all deq data outputs=0.
  - Storage array contents are don't-care.
- Reset release is synchronous to clk. Reset asserted mid-operation drops all entries immediately.
- enq_ready_o = (count != DEPTH). It is combinational from state only; it does not depend on deq_ready_i or flush_i.
- Enqueue fires when enq_valid_i & enq_ready_o & !flush_i:
  - write the triple at wr_ptr;
  - wr_ptr += 1, wrapping DEPTH-1 -> 0.
- deq_valid_o = (count != 0).
- deq data outputs:
  - show the entry at rd_ptr, read combinationally from storage;
  - forced to all-zero when count == 0, which is the NOP-free bubble value.
- Dequeue fires when deq_valid_o & deq_ready_i & !flush_i: rd_ptr += 1 with wrap.
- Count update when not flushing:
  - +1 on enqueue only;
  - -1 on dequeue only;
  - unchanged on both or neither.
- Simultaneous enqueue and dequeue:
  - allowed at any non-full, non-empty occupancy;
  - when empty, only the enqueue can fire, so count goes 0 -> 1;
  - when full, only the dequeue can fire, since enq_ready_o=0.
- No bypass: an entry written in cycle N is first visible on deq_* in cycle N+1. Minimum latency is 1 cycle.
- Flush (flush_i=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0;
  - any enqueue or dequeue in that cycle is discarded;
  - next cycle: deq_valid_o=0, enq_ready_o=1.
- Flush has priority over everything except reset.
- Data stability: while deq_valid_o=1 and deq_ready_i=0 with no flush, the deq_* outputs hold constant.
- Full boundary: at count==DEPTH, enq_valid_i is ignored, with no overwrite and no pointer movement.
- Empty boundary: at count==0, deq_ready_i is ignored, with no pointer movement.
- Pointer wrap: pointers are PTR_W bits with natural wrap. count disambiguates full from empty.

Test Plan:
- Reset then fill: enqueue pc=0x00,0x04,0x08,0x0C (instr=0xA0..0xA3) with deq_ready_i=0.
  - count_o goes 1,2,3,4.
  - enq_ready_o=0 after the 4th.
  - A 5th enqueue of pc=0x10 is dropped: count stays 4 and the head stays pc=0x00.
- Drain in order: from full, set deq_ready_i=1 for 4 cycles.
  - deq_pc_o shows 0x00,0x04,0x08,0x0C.
  - pc_plus4 shows 0x04,0x08,0x0C,0x10.
  - Then deq_valid_o=0, deq data=0, count_o=0.
- Streaming: enq_valid_i=1 and deq_ready_i=1 continuously with pc stepping by 4 from 0x100.
  - count_o stays 1 after the first cycle.
  - Each pc appears on deq_pc_o exactly one cycle after enqueue.
  - 12 entries pass in order, covering wrap-around three times.
- Flush mid-stream: with count=3 (pc 0x20,0x24,0x28), assert flush_i together with enq_valid_i (pc=0x2C) and deq_ready_i.
  - Next cycle: count_o=0, deq_valid_o=0, enq_ready_o=1.
  - The following enqueue of pc=0x80 appears as head with count 1.
- Stall hold: count=2 with head pc=0x40, deq_ready_i=0 for 5 cycles.
  - deq_pc_o=0x40 and deq_instr_o remain stable every cycle.
  - count_o=2 throughout.
- Async reset mid-operation: with count=3, pulse rst_n low between clock edges.
  - Outputs go to reset values immediately, before the next edge: deq_valid_o=0, count_o=0, enq_ready_o=1.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: circular FIFO of {pc, instr, pc_plus4}
// triples with valid/ready on both sides and a branch-redirect flush.
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  enq_valid_i,
    input  logic [DATA_WIDTH-1:0] enq_pc_i,
    input  logic [DATA_WIDTH-1:0] enq_instr_i,
    input  logic [DATA_WIDTH-1:0] enq_pc_plus4_i,
    output logic                  enq_ready_o,
    output logic                  deq_valid_o,
    output logic [DATA_WIDTH-1:0] deq_pc_o,
    output logic [DATA_WIDTH-1:0] deq_instr_o,
    output logic [DATA_WIDTH-1:0] deq_pc_plus4_o,
    input  logic                  deq_ready_i,
    output logic [CNT_W-1:0]      count_o
);

    localparam int ENTRY_W = 3 * DATA_WIDTH;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               enq_fire;
    logic               deq_fire;
    logic [ENTRY_W-1:0] head;

    assign enq_ready_o = (count_q != CNT_W'(DEPTH));
    assign deq_valid_o = (count_q != '0);
    assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;
    assign deq_fire    = deq_valid_o & deq_ready_i & ~flush_i;

    // Empty queue presents an all-zero bubble rather than stale storage.
    assign head = deq_valid_o ? mem_q[rd_ptr_q] : '0;
    assign deq_pc_o       = head[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign deq_instr_o    = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign deq_pc_plus4_o = head[DATA_WIDTH-1:0];
    assign count_o        = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq_fire && !deq_fire)      count_d = count_q + CNT_W'(1);
            else if (!enq_fire && deq_fire) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[wr_ptr_q] <= {enq_pc_i, enq_instr_i, enq_pc_plus4_i};
    end

endmodule
